// File: rtl/rom_burst_reader.sv
// Burst reader for a small async ROM: walks consecutive addresses and hands
// each word downstream on valid/ready. Optional running checksum: ROM_SUM_EN.
module rom_burst_reader #(
   parameter int AW       = 4,
   parameter int DW       = 4,
   parameter int WAIT_CYC = 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   input  logic [AW-1:0] i_base_addr,
   input  logic [AW-1:0] i_count,
   output logic          o_busy,
   output logic          o_rom_ce_n,
   output logic          o_rom_oe_n,
   output logic [AW-1:0] o_rom_addr,
   input  logic [DW-1:0] i_rom_data,
   output logic [DW-1:0] o_out_data,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic          o_done
`ifdef ROM_SUM_EN
  ,output logic [DW-1:0] o_checksum
`endif
);

   localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam logic [WW-1:0] LAST = WW'(WAIT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HOLD} state_t;

   state_t        r_state;
   state_t        w_next;
   logic          w_accept;
   logic          w_capture;
   logic          w_advance;
   logic          w_finish;
   logic [AW-1:0] r_remaining;
   logic [AW-1:0] r_addr;
   logic [WW-1:0] r_wait;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          r_busy;
   logic          r_ce_n;
   logic          r_done;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // A start coinciding with done is dropped; IDLE only listens once done is low.
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      w_advance = 1'b0;
      w_finish  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start && !r_done) begin
               w_accept = 1'b1;
               w_next   = S_SETUP;
            end
         end
         S_SETUP: begin
            if (r_wait == LAST) begin
               w_capture = 1'b1;
               w_next    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (i_out_ready) begin
               if (r_remaining == '0) begin
                  w_finish = 1'b1;
                  w_next   = S_IDLE;
               end else begin
                  w_advance = 1'b1;
                  w_next    = S_SETUP;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_remaining <= '0;
         r_addr      <= '0;
         r_wait      <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_ce_n      <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (r_state == S_SETUP) r_wait <= r_wait + WW'(1);
         if (w_accept) begin
            r_remaining <= i_count;
            r_addr      <= i_base_addr;
            r_busy      <= 1'b1;
            r_ce_n      <= 1'b0;
            r_wait      <= '0;
         end
         if (w_capture) begin
            r_data  <= i_rom_data;
            r_valid <= 1'b1;
            r_ce_n  <= 1'b1;
         end
         if (w_advance) begin
            r_addr      <= r_addr + AW'(1);
            r_remaining <= r_remaining - AW'(1);
            r_valid     <= 1'b0;
            r_ce_n      <= 1'b0;
            r_wait      <= '0;
         end
         if (w_finish) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
         end
      end
   end

`ifdef ROM_SUM_EN
   logic [DW-1:0] r_sum;

   always_ff @(posedge i_clk) begin
      if (i_reset)        r_sum <= '0;
      else if (w_accept)  r_sum <= '0;
      else if (w_capture) r_sum <= r_sum + i_rom_data;
   end

   assign o_checksum = r_sum;
`endif

   // One enable register feeds both strobes so they can never diverge.
   assign o_busy      = r_busy;
   assign o_rom_ce_n  = r_ce_n;
   assign o_rom_oe_n  = r_ce_n;
   assign o_rom_addr  = r_addr;
   assign o_out_data  = r_data;
   assign o_out_valid = r_valid;
   assign o_done      = r_done;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: directed burst table, stall/start/reset
// sequences, and random bursts against a queue-based model.
module tb_rom_burst_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] base_addr;
   logic [3:0] count;
   logic       busy;
   logic       rom_ce_n;
   logic       rom_oe_n;
   logic [3:0] rom_addr;
   logic [3:0] rom_data;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       done;
`ifdef ROM_SUM_EN
   logic [3:0] checksum;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [3:0] rom_word(input logic [3:0] a);
      return {a[2:0], a[3]};
   endfunction

   assign rom_data = rom_word(rom_addr);

   rom_burst_reader dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_start     (start),
      .i_base_addr (base_addr),
      .i_count     (count),
      .o_busy      (busy),
      .o_rom_ce_n  (rom_ce_n),
      .o_rom_oe_n  (rom_oe_n),
      .o_rom_addr  (rom_addr),
      .i_rom_data  (rom_data),
      .o_out_data  (out_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_done      (done)
`ifdef ROM_SUM_EN
     ,.o_checksum  (checksum)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_ce_n"}, 32'(rom_ce_n), 1);
      chk({tag, "_oe_n"}, 32'(rom_oe_n), 1);
      chk({tag, "_addr"}, 32'(rom_addr), 0);
      chk({tag, "_data"}, 32'(out_data), 0);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_done"}, 32'(done), 0);
`ifdef ROM_SUM_EN
      chk({tag, "_sum"}, 32'(checksum), 0);
`endif
   endtask

   // Called at a negedge with the DUT idle. Model: queue of expected words.
   task automatic run_burst(input logic [3:0] b, input logic [3:0] c,
                            input bit rnd, output int cycles,
                            output logic [3:0] first, output logic [3:0] last,
                            output logic [3:0] sum);
      logic [3:0] q[$];
      logic [3:0] exp_addr[$];
      bit got_done;
      q.delete();
      exp_addr.delete();
      sum = '0;
      for (int i = 0; i <= int'(c); i++) begin
         exp_addr.push_back(4'(b + 4'(i)));
         q.push_back(rom_word(4'(b + 4'(i))));
         sum = sum + rom_word(4'(b + 4'(i)));
      end
      first = q[0];
      last  = q[$];
      start = 1'b1;
      base_addr = b;
      count = c;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 1);
      cycles = 0;
      got_done = 1'b0;
      while (!got_done && cycles < 200) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rnd) begin
            start = 1'($urandom_range(0, 1));
            base_addr = 4'($urandom);
            count = 4'($urandom);
         end
         if (rom_ce_n !== rom_oe_n) chk("ce_oe_pair", 32'(rom_oe_n), 32'(rom_ce_n));
         if (out_valid) begin
            if (rom_ce_n !== 1'b1) chk("ce_high_hold", 32'(rom_ce_n), 1);
            if (exp_addr.size() == 0) begin
               chk("extra_word", 1, 0);
            end else if (out_ready) begin
               chk("word_addr", 32'(rom_addr), 32'(exp_addr.pop_front()));
               chk("word_data", 32'(out_data), 32'(q.pop_front()));
            end
         end else if (busy && rom_ce_n !== 1'b0) begin
            chk("ce_low_setup", 32'(rom_ce_n), 0);
         end
         @(negedge clk);
         cycles++;
         if (done) got_done = 1'b1;
      end
      start = 1'b0;
      if (!got_done) chk("done_timeout", 0, 1);
      chk("words_left", 32'(q.size()), 0);
      chk("busy_at_done", 32'(busy), 0);
`ifdef ROM_SUM_EN
      chk("checksum", 32'(checksum), 32'(sum));
`endif
      out_ready = 1'b1;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 0);
   endtask

   typedef struct {
      logic [3:0] base;
      logic [3:0] cnt;
      int         cyc;
      logic [3:0] first;
      logic [3:0] last;
      logic [3:0] sum;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int cyc;
      logic [3:0] f, l, s;
      int guard;
      vecs[0] = '{4'd0,  4'd3,  8,  4'd0,  4'd6,  4'd12};
      vecs[1] = '{4'd14, 4'd3,  8,  4'd13, 4'd2,  4'd14};
      vecs[2] = '{4'd0,  4'd15, 32, 4'd0,  4'd15, 4'd8};
      vecs[3] = '{4'd5,  4'd0,  2,  4'd10, 4'd10, 4'd10};

      reset = 1'b1;
      start = 1'b0;
      base_addr = '0;
      count = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("por");
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_burst(vecs[i].base, vecs[i].cnt, 1'b0, cyc, f, l, s);
         chk("tbl_cycles", 32'(cyc), 32'(vecs[i].cyc));
         chk("tbl_first", 32'(f), 32'(vecs[i].first));
         chk("tbl_last", 32'(l), 32'(vecs[i].last));
         chk("tbl_sum", 32'(s), 32'(vecs[i].sum));
      end

      // Stall on word 0 for five cycles.
      start = 1'b1;
      base_addr = 4'd0;
      count = 4'd1;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_data", 32'(out_data), 0);
         chk("stall_ce_n", 32'(rom_ce_n), 1);
         chk("stall_addr", 32'(rom_addr), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_addr1", 32'(rom_addr), 1);
      @(negedge clk);
      chk("stall_word1", 32'(out_data), 2);
      chk("stall_valid1", 32'(out_valid), 1);
      @(negedge clk);
      chk("stall_done", 32'(done), 1);

      // Start held through done is ignored, then accepted one cycle later.
      start = 1'b1;
      base_addr = 4'd3;
      count = 4'd0;
      @(negedge clk);
      chk("start_on_done_ignored", 32'(busy), 0);
      @(negedge clk);
      start = 1'b0;
      chk("start_after_done", 32'(busy), 1);
      chk("start_after_addr", 32'(rom_addr), 3);
      guard = 0;
      while (!done && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("late_start_done", 32'(done), 1);
      @(negedge clk);

      // Reset mid-burst.
      start = 1'b1;
      base_addr = 4'd9;
      count = 4'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("mid_rst");
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no_done_after_rst", 32'(done), 0);
         chk("idle_after_rst", 32'(busy), 0);
      end

      for (int n = 0; n < 20; n++) begin
         run_burst(4'($urandom), 4'($urandom), 1'b1, cyc, f, l, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
